// File: rtl/common_pkg.sv
// Shared constants and types for the RAM bus arbiter: period geometry,
// window boundaries and the arbiter state encoding.
package common_pkg;

    localparam int ARB_PERIOD_CYCLES = 32;
    localparam int SLOT_W            = $clog2(ARB_PERIOD_CYCLES);

    localparam logic [SLOT_W-1:0] VIDEO_FIRST     = 5'd0;
    localparam logic [SLOT_W-1:0] VIDEO_LOAD_SLOT = 5'd6;
    localparam logic [SLOT_W-1:0] WBA_FIRST       = 5'd8;
    localparam logic [SLOT_W-1:0] WBA_LAST        = 5'd15;
    localparam logic [SLOT_W-1:0] CPU_FIRST       = 5'd16;
    localparam logic [SLOT_W-1:0] CPU_LAST        = 5'd23;
    localparam logic [SLOT_W-1:0] WBB_FIRST       = 5'd24;
    localparam logic [SLOT_W-1:0] WBB_LAST        = 5'd31;
    localparam logic [SLOT_W-1:0] CPU_EN_SLOT     = 5'd31;

    localparam logic [2:0] GRANT_NONE  = 3'b000;
    localparam logic [2:0] GRANT_VIDEO = 3'b001;
    localparam logic [2:0] GRANT_CPU   = 3'b010;
    localparam logic [2:0] GRANT_WB    = 3'b100;

    typedef enum logic [2:0] {
        ARB_VIDEO     = 3'd0,
        ARB_CPU       = 3'd1,
        ARB_WB_IDLE   = 3'd2,
        ARB_WB_ACTIVE = 3'd3,
        ARB_WB_DONE   = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        WIN_VIDEO = 2'd0,
        WIN_WB_A  = 2'd1,
        WIN_CPU   = 2'd2,
        WIN_WB_B  = 2'd3
    } window_t;

    function automatic window_t window_of(input logic [SLOT_W-1:0] slot);
        if (slot < WBA_FIRST)      return WIN_VIDEO;
        else if (slot < CPU_FIRST) return WIN_WB_A;
        else if (slot < WBB_FIRST) return WIN_CPU;
        else                       return WIN_WB_B;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Time-sliced RAM bus arbiter: a 32-slot period split into video, CPU and
// two Wishbone windows, with one-cycle load/enable/timeout pulses.
module ram_arbiter
    import common_pkg::*;
(
    input  logic              wb_clock_i,
    input  logic              wb_reset_i,
    input  logic              cpu_ready_i,
    input  logic              wb_req_i,
    input  logic              wb_done_i,
    output logic [2:0]        grant_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              cpu_en_o,
    output logic              video_load_o,
    output logic              wb_timeout_o,
    output arb_state_t        arb_state
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_next;
    logic              running_q;
    arb_state_t        state_q;
    arb_state_t        state_next;
    logic              cpu_ok_q;
    logic              video_load_q;
    logic              cpu_en_q;
    logic              timeout_q;
    logic              wb_last;

    // The first clock after reset release holds slot 0 so the period starts
    // with a full video slot 0 rather than skipping straight to slot 1.
    always_comb begin
        slot_next  = running_q ? slot_q + 5'd1 : '0;
        wb_last    = (slot_q == WBA_LAST) || (slot_q == WBB_LAST);
        state_next = state_q;
        case (window_of(slot_next))
            WIN_VIDEO: state_next = ARB_VIDEO;
            WIN_CPU:   state_next = ARB_CPU;
            default: begin
                // wb_req_i is taken at the edge that opens the window, so a
                // granted request owns the bus from the window's first slot.
                if ((slot_next == WBA_FIRST) || (slot_next == WBB_FIRST)) begin
                    state_next = wb_req_i ? ARB_WB_ACTIVE : ARB_WB_IDLE;
                end else if ((state_q == ARB_WB_ACTIVE) && wb_done_i) begin
                    state_next = ARB_WB_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            slot_q       <= '0;
            running_q    <= 1'b0;
            state_q      <= ARB_VIDEO;
            cpu_ok_q     <= 1'b0;
            video_load_q <= 1'b0;
            cpu_en_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            slot_q       <= slot_next;
            running_q    <= 1'b1;
            state_q      <= state_next;
            if (running_q && (slot_q == CPU_LAST)) begin
                cpu_ok_q <= cpu_ready_i;
            end
            video_load_q <= (slot_next == VIDEO_LOAD_SLOT);
            cpu_en_q     <= (slot_next == CPU_EN_SLOT) && cpu_ok_q;
            timeout_q    <= (state_q == ARB_WB_ACTIVE) && wb_last && !wb_done_i;
        end
    end

    always_comb begin
        grant_o = GRANT_NONE;
        if (running_q) begin
            case (state_q)
                ARB_VIDEO:     grant_o = GRANT_VIDEO;
                ARB_CPU:       grant_o = GRANT_CPU;
                ARB_WB_ACTIVE: grant_o = GRANT_WB;
                default:       grant_o = GRANT_NONE;
            endcase
        end
    end

    assign slot_o       = slot_q;
    assign cpu_en_o     = cpu_en_q;
    assign video_load_o = video_load_q;
    assign wb_timeout_o = timeout_q;
    assign arb_state    = state_q;

endmodule
